retire_stats_monitor: RTL and testbench

- Parametrised retirement-statistics collector with a watchdog, for the rv32core bench and optional on-chip debug.
- Monitors NRET retire lanes and counts instructions, branches, loads, stores, jumps and exceptions.
- Ends a test run on an explicit stop, on an instruction limit, or on a no-progress timeout.
- Next generation of the single-lane stats record plus fixed timeout: multi-lane, width-configurable, saturating, with a run-control FSM.

---
 rtl/retire_stats_monitor.sv | 166 ++++++++++++++++
 tb/tb_retire_stats_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/retire_stats_monitor.sv
// Retirement statistics collector with run-control FSM and no-progress watchdog.
// Counts retired instructions per class across NRET lanes, saturating at CNT_W.
// Optional RUN-cycle counter enabled by defining RETIRE_STATS_CYCLE_CNT_EN;
// when undefined, cycles_o is tied to zero.
// CNT_W must be at least 3 so a full-lane increment fits the counter width.
module retire_stats_monitor #(
  parameter int NRET           = 1,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int MAX_INSTR      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                clr_i,
  input  logic [NRET-1:0]     ret_valid_i,
  input  logic [3*NRET-1:0]   ret_class_i,
  input  logic [NRET-1:0]     ret_exc_i,
  output logic [CNT_W-1:0]    num_instr_o,
  output logic [CNT_W-1:0]    num_branch_o,
  output logic [CNT_W-1:0]    num_load_o,
  output logic [CNT_W-1:0]    num_store_o,
  output logic [CNT_W-1:0]    num_jump_o,
  output logic [CNT_W-1:0]    num_exc_o,
  output logic [CNT_W-1:0]    cycles_o,
  output logic [1:0]          state_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  localparam int          WD_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [63:0] MAX_L = 64'(MAX_INSTR);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] instr_q, branch_q, load_q, store_q, jump_q, exc_q;
  logic [CNT_W-1:0] instr_nxt;
  logic [WD_W-1:0]  wd_q, wd_nxt;
  logic [2:0]       inc_instr, inc_branch, inc_load, inc_store, inc_jump, inc_exc;
  logic             any_valid;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Per-lane decode into popcount increments; exception lanes bypass class counters.
  always_comb begin
    inc_instr  = '0;
    inc_branch = '0;
    inc_load   = '0;
    inc_store  = '0;
    inc_jump   = '0;
    inc_exc    = '0;
    any_valid  = 1'b0;
    for (int unsigned k = 0; k < NRET; k++) begin
      if (ret_valid_i[k]) begin
        any_valid = 1'b1;
        if (ret_exc_i[k]) begin
          inc_exc = inc_exc + 3'd1;
        end else begin
          inc_instr = inc_instr + 3'd1;
          case (ret_class_i[3*k +: 3])
            3'd1:    inc_branch = inc_branch + 3'd1;
            3'd2:    inc_load   = inc_load + 3'd1;
            3'd3:    inc_store  = inc_store + 3'd1;
            3'd4:    inc_jump   = inc_jump + 3'd1;
            default: ;
          endcase
        end
      end
    end
    instr_nxt = sat_add(instr_q, inc_instr);
    wd_nxt    = any_valid ? '0 : wd_q + WD_W'(1);
  end

  // Run-control next state; stop beats instruction limit beats watchdog.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_i) state_nxt = S_RUN;
      S_RUN: begin
        if (stop_i)
          state_nxt = S_DONE;
        else if (MAX_INSTR != 0 && 64'(instr_nxt) >= MAX_L)
          state_nxt = S_DONE;
        else if (wd_nxt == WD_W'(TIMEOUT_CYCLES))
          state_nxt = S_TIMEOUT;
      end
      S_DONE,
      S_TIMEOUT: if (clr_i) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Statistics and watchdog: cleared on start, updated only while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= '0;
      branch_q <= '0;
      load_q   <= '0;
      store_q  <= '0;
      jump_q   <= '0;
      exc_q    <= '0;
      wd_q     <= '0;
    end else if (state == S_IDLE && start_i) begin
      instr_q  <= '0;
      branch_q <= '0;
      load_q   <= '0;
      store_q  <= '0;
      jump_q   <= '0;
      exc_q    <= '0;
      wd_q     <= '0;
    end else if (state == S_RUN) begin
      instr_q  <= instr_nxt;
      branch_q <= sat_add(branch_q, inc_branch);
      load_q   <= sat_add(load_q, inc_load);
      store_q  <= sat_add(store_q, inc_store);
      jump_q   <= sat_add(jump_q, inc_jump);
      exc_q    <= sat_add(exc_q, inc_exc);
      wd_q     <= wd_nxt;
    end
  end

`ifdef RETIRE_STATS_CYCLE_CNT_EN
  logic [CNT_W-1:0] cycles_q;

  // RUN cycle counter, including the exit cycle; frozen outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cycles_q <= '0;
    else if (state == S_IDLE && start_i) cycles_q <= '0;
    else if (state == S_RUN)           cycles_q <= sat_add(cycles_q, 3'd1);
  end

  assign cycles_o = cycles_q;
`else
  assign cycles_o = '0;
`endif

  assign num_instr_o  = instr_q;
  assign num_branch_o = branch_q;
  assign num_load_o   = load_q;
  assign num_store_o  = store_q;
  assign num_jump_o   = jump_q;
  assign num_exc_o    = exc_q;
  assign state_o      = state;
  assign busy_o       = (state == S_RUN);
  assign done_o       = (state == S_DONE);
  assign timeout_o    = (state == S_TIMEOUT);

endmodule

// File: tb/tb_retire_stats_monitor.sv
// Scoreboard bench for retire_stats_monitor across five parameterisations.
// Stimulus pushes expected snapshots; a negedge monitor pops and compares.
module tb_retire_stats_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] start = '0, stop = '0, clr = '0;
  logic [2:0] rv = '0;
  logic [8:0] rc = '0;
  logic [2:0] re = '0;

  logic [4:0][31:0] o_instr, o_br, o_ld, o_st, o_jmp, o_exc, o_cyc;
  logic [4:0][1:0]  o_state;
  logic [4:0]       o_busy, o_done, o_to;
  logic [3:0]       p_instr, p_br, p_ld, p_st, p_jmp, p_exc, p_cyc;

  always #5 clk = ~clk;

  // u0: NRET=1 defaults
  retire_stats_monitor #(.NRET(1), .CNT_W(32), .TIMEOUT_CYCLES(10000), .MAX_INSTR(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .stop_i(stop[0]), .clr_i(clr[0]),
    .ret_valid_i(rv[0:0]), .ret_class_i(rc[2:0]), .ret_exc_i(re[0:0]),
    .num_instr_o(o_instr[0]), .num_branch_o(o_br[0]), .num_load_o(o_ld[0]),
    .num_store_o(o_st[0]), .num_jump_o(o_jmp[0]), .num_exc_o(o_exc[0]), .cycles_o(o_cyc[0]),
    .state_o(o_state[0]), .busy_o(o_busy[0]), .done_o(o_done[0]), .timeout_o(o_to[0]));

  // u1: NRET=2, short watchdog
  retire_stats_monitor #(.NRET(2), .CNT_W(32), .TIMEOUT_CYCLES(8), .MAX_INSTR(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .stop_i(stop[1]), .clr_i(clr[1]),
    .ret_valid_i(rv[1:0]), .ret_class_i(rc[5:0]), .ret_exc_i(re[1:0]),
    .num_instr_o(o_instr[1]), .num_branch_o(o_br[1]), .num_load_o(o_ld[1]),
    .num_store_o(o_st[1]), .num_jump_o(o_jmp[1]), .num_exc_o(o_exc[1]), .cycles_o(o_cyc[1]),
    .state_o(o_state[1]), .busy_o(o_busy[1]), .done_o(o_done[1]), .timeout_o(o_to[1]));

  // u2: NRET=2, limit 4
  retire_stats_monitor #(.NRET(2), .CNT_W(32), .TIMEOUT_CYCLES(10000), .MAX_INSTR(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start_i(start[2]), .stop_i(stop[2]), .clr_i(clr[2]),
    .ret_valid_i(rv[1:0]), .ret_class_i(rc[5:0]), .ret_exc_i(re[1:0]),
    .num_instr_o(o_instr[2]), .num_branch_o(o_br[2]), .num_load_o(o_ld[2]),
    .num_store_o(o_st[2]), .num_jump_o(o_jmp[2]), .num_exc_o(o_exc[2]), .cycles_o(o_cyc[2]),
    .state_o(o_state[2]), .busy_o(o_busy[2]), .done_o(o_done[2]), .timeout_o(o_to[2]));

  // u3: NRET=3, limit 5
  retire_stats_monitor #(.NRET(3), .CNT_W(32), .TIMEOUT_CYCLES(10000), .MAX_INSTR(5)) u3 (
    .clk(clk), .rst_n(rst_n), .start_i(start[3]), .stop_i(stop[3]), .clr_i(clr[3]),
    .ret_valid_i(rv[2:0]), .ret_class_i(rc[8:0]), .ret_exc_i(re[2:0]),
    .num_instr_o(o_instr[3]), .num_branch_o(o_br[3]), .num_load_o(o_ld[3]),
    .num_store_o(o_st[3]), .num_jump_o(o_jmp[3]), .num_exc_o(o_exc[3]), .cycles_o(o_cyc[3]),
    .state_o(o_state[3]), .busy_o(o_busy[3]), .done_o(o_done[3]), .timeout_o(o_to[3]));

  // u4: NRET=1, 4-bit counters
  retire_stats_monitor #(.NRET(1), .CNT_W(4), .TIMEOUT_CYCLES(10000), .MAX_INSTR(0)) u4 (
    .clk(clk), .rst_n(rst_n), .start_i(start[4]), .stop_i(stop[4]), .clr_i(clr[4]),
    .ret_valid_i(rv[0:0]), .ret_class_i(rc[2:0]), .ret_exc_i(re[0:0]),
    .num_instr_o(p_instr), .num_branch_o(p_br), .num_load_o(p_ld),
    .num_store_o(p_st), .num_jump_o(p_jmp), .num_exc_o(p_exc), .cycles_o(p_cyc),
    .state_o(o_state[4]), .busy_o(o_busy[4]), .done_o(o_done[4]), .timeout_o(o_to[4]));

  assign o_instr[4] = {28'd0, p_instr};
  assign o_br[4]    = {28'd0, p_br};
  assign o_ld[4]    = {28'd0, p_ld};
  assign o_st[4]    = {28'd0, p_st};
  assign o_jmp[4]   = {28'd0, p_jmp};
  assign o_exc[4]   = {28'd0, p_exc};
  assign o_cyc[4]   = {28'd0, p_cyc};

  typedef struct packed {
    logic [2:0]  inst;
    logic [1:0]  st;
    logic [31:0] instr, br, ld, sto, jmp, exc, cyc;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    n_pass = 0, n_total = 0;

  function automatic logic [31:0] cy(input int v);
`ifdef RETIRE_STATS_CYCLE_CNT_EN
    return 32'(v);
`else
    return (v == v) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic push(input int inst, input string nm, input logic [1:0] st,
                      input int instr, input int br, input int ld, input int sto,
                      input int jmp, input int exc, input int cyc);
    exp_t e;
    e.inst = 3'(inst); e.st = st;
    e.instr = 32'(instr); e.br = 32'(br); e.ld = 32'(ld); e.sto = 32'(sto);
    e.jmp = 32'(jmp); e.exc = 32'(exc); e.cyc = cy(cyc);
    q.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s got %0d expected %0d", nm, fld, act, exp);
  endtask

  exp_t  m_e;
  string m_nm;
  int    m_i;

  // Monitor: compare every queued expectation against the addressed instance.
  always @(negedge clk) begin
    while (q.size() != 0) begin
      m_e  = q.pop_front();
      m_nm = nq.pop_front();
      m_i  = int'(m_e.inst);
      chk(m_nm, "state",  32'(o_state[m_i]), 32'(m_e.st));
      chk(m_nm, "flags",  32'({o_busy[m_i], o_done[m_i], o_to[m_i]}),
          32'({m_e.st == 2'd1, m_e.st == 2'd2, m_e.st == 2'd3}));
      chk(m_nm, "instr",  o_instr[m_i], m_e.instr);
      chk(m_nm, "branch", o_br[m_i],    m_e.br);
      chk(m_nm, "load",   o_ld[m_i],    m_e.ld);
      chk(m_nm, "store",  o_st[m_i],    m_e.sto);
      chk(m_nm, "jump",   o_jmp[m_i],   m_e.jmp);
      chk(m_nm, "exc",    o_exc[m_i],   m_e.exc);
      chk(m_nm, "cycles", o_cyc[m_i],   m_e.cyc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int cls_seq[10] = '{0, 0, 0, 0, 0, 1, 1, 2, 3, 4};

  initial begin
    #1;
    for (int i = 0; i < 5; i++) push(i, "reset", 2'd0, 0, 0, 0, 0, 0, 0, 0);
    #11 rst_n = 1'b1;
    tick();

    // u0: mixed classes, start ignored mid-run, then stop
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rv = 3'b001; rc = 9'(cls_seq[i]); re = '0;
      start[0] = (i == 4);
      tick();
    end
    start[0] = 1'b0; rv = '0; rc = '0;
    stop[0] = 1'b1; tick(); stop[0] = 1'b0;
    push(0, "u0_stop", 2'd2, 10, 2, 1, 1, 1, 0, 11);

    // u1: lane0 load, lane1 exception (branch class excluded)
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rv = 3'b011; rc = 9'b000_001_010; re = 3'b010;
      tick();
    end
    rv = '0; re = '0; rc = '0;
    stop[1] = 1'b1; tick(); stop[1] = 1'b0;
    push(1, "u1_exc_done", 2'd2, 3, 0, 3, 0, 0, 3, 4);
    clr[1] = 1'b1; tick(); clr[1] = 1'b0;
    push(1, "u1_clr_held", 2'd0, 3, 0, 3, 0, 0, 3, 4);
    rv = 3'b011; rc = 9'b000_010_010; tick(); rv = '0; rc = '0;
    push(1, "u1_idle_ignore", 2'd0, 3, 0, 3, 0, 0, 3, 4);

    // u1: start clears, watchdog expires 8 cycles after RUN entry
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    push(1, "u1_start_clear", 2'd1, 0, 0, 0, 0, 0, 0, 0);
    repeat (7) tick();
    push(1, "u1_wd_7", 2'd1, 0, 0, 0, 0, 0, 0, 7);
    tick();
    push(1, "u1_timeout", 2'd3, 0, 0, 0, 0, 0, 0, 8);
    start[1] = 1'b1; stop[1] = 1'b1; tick(); start[1] = 1'b0; stop[1] = 1'b0;
    push(1, "u1_to_ignore", 2'd3, 0, 0, 0, 0, 0, 0, 8);
    clr[1] = 1'b1; tick(); clr[1] = 1'b0;
    push(1, "u1_to_clr", 2'd0, 0, 0, 0, 0, 0, 0, 8);

    // u1: stop and watchdog expiry coincide
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    repeat (7) tick();
    stop[1] = 1'b1; tick(); stop[1] = 1'b0;
    push(1, "u1_stop_vs_wd", 2'd2, 0, 0, 0, 0, 0, 0, 8);

    // u2: two ALU lanes per cycle against limit 4
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    rv = 3'b011; rc = '0; re = '0;
    tick();
    push(2, "u2_limit_mid", 2'd1, 2, 0, 0, 0, 0, 0, 1);
    tick();
    push(2, "u2_limit_done", 2'd2, 4, 0, 0, 0, 0, 0, 2);
    tick();
    push(2, "u2_frozen", 2'd2, 4, 0, 0, 0, 0, 0, 2);
    rv = '0;

    // u3: three lanes crossing limit 5
    start[3] = 1'b1; tick(); start[3] = 1'b0;
    rv = 3'b111; rc = '0;
    tick();
    push(3, "u3_limit_mid", 2'd1, 3, 0, 0, 0, 0, 0, 1);
    tick();
    push(3, "u3_overshoot", 2'd2, 6, 0, 0, 0, 0, 0, 2);
    rv = '0;

    // u4: 4-bit counters saturate
    start[4] = 1'b1; tick(); start[4] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rv = 3'b001; rc = '0;
      tick();
      if (i == 14) push(4, "u4_sat_edge", 2'd1, 15, 0, 0, 0, 0, 0, 15);
    end
    rv = '0;
    stop[4] = 1'b1; tick(); stop[4] = 1'b0;
    push(4, "u4_sat_done", 2'd2, 15, 0, 0, 0, 0, 0, 15);

    // u0: asynchronous reset mid-run
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    push(0, "u0_clr_held", 2'd0, 10, 2, 1, 1, 1, 0, 11);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    repeat (7) begin rv = 3'b001; rc = '0; tick(); end
    rv = '0;
    push(0, "u0_pre_reset", 2'd1, 7, 0, 0, 0, 0, 0, 7);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) push(i, "async_reset", 2'd0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (2) tick();
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
